// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the word FIFO slice.
//   - fifo_count_width(m): width of the pointers and of the occupancy count of a
//     2**m-deep FIFO. One extra bit lets "full" and "empty" be told apart when
//     the index bits of the two pointers are equal.
//   - Handshake field names used by the FIFOInterface-style ports
//     (ready/valid/data). They are documentation constants only, so that tools
//     and scripts across the codebase agree on the naming.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam string FIFO_READY_FIELD = "ready";
  localparam string FIFO_VALID_FIELD = "valid";
  localparam string FIFO_DATA_FIELD  = "data";

  function automatic int fifo_count_width(input int m);
    return m + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// N x Nb storage array (N = 2**M) for sync_word_fifo.
// One synchronous write port and one asynchronous (combinational) read port,
// which is what gives the FIFO its first-word-fall-through behaviour.
// Ports:
//   clk    in   1    write clock
//   we     in   1    write enable
//   waddr  in   M    write index
//   wdata  in   Nb   write word
//   raddr  in   M    read index
//   rdata  out  Nb   word at raddr (combinational)
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int Nb = 32,
  parameter int M  = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [M-1:0]  waddr,
  input  logic [Nb-1:0] wdata,
  input  logic [M-1:0]  raddr,
  output logic [Nb-1:0] rdata
);

  localparam int N = 2 ** M;

  logic [Nb-1:0] mem [N];

  // NOTE: the array has no reset. Entries are only ever read after being
  // written, and a resettable array would prevent mapping onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/sync_word_fifo.sv
// -----------------------------------------------------------------------------
// sync_word_fifo
// Single-clock, first-word-fall-through word FIFO with ready/valid handshakes
// on both sides and an occupancy count. Used as the per-port buffer in front
// of the memory FIFO arbiter, which sizes its bursts from `count`.
//
// Parameters:
//   Nb        data word width
//   M         log2 of depth (N = 2**M words)
//   AF_LEVEL  almost-full threshold (only with SYNC_FIFO_ALMOST_FULL_EN)
// Ports:
//   clk          in   1     clock, all state changes on posedge
//   reset        in   1     asynchronous, active-low reset
//   in_ready     out  1     a word can be accepted this cycle
//   in_valid     in   1     producer offers in_data
//   in_data      in   Nb    write word
//   out_ready    in   1     consumer takes out_data this cycle
//   out_valid    out  1     out_data holds the head word
//   out_data     out  Nb    head word (0 while empty)
//   count        out  M+1   occupancy, 0..N
//   almost_full  out  1     registered (count >= AF_LEVEL); only present when
//                           the macro SYNC_FIFO_ALMOST_FULL_EN is defined
//
// Flags come from registered pointers only, so in_ready never depends on
// in_valid and out_valid never depends on out_ready. The consequence is that
// a full FIFO cannot accept a word in the same cycle it frees a slot, and an
// empty FIFO never bypasses a pushed word straight to the output.
// -----------------------------------------------------------------------------
module sync_word_fifo
  import fifo_pkg::*;
#(
  parameter int Nb = 32,
  parameter int M  = 6
`ifdef SYNC_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = (2 ** M) - 4
`endif
) (
  input  logic          clk,
  input  logic          reset,
  output logic          in_ready,
  input  logic          in_valid,
  input  logic [Nb-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [Nb-1:0] out_data,
  output logic [M:0]    count
`ifdef SYNC_FIFO_ALMOST_FULL_EN
  ,
  output logic          almost_full
`endif
);

  localparam int              N           = 2 ** M;
  localparam int              CW          = fifo_count_width(M);
  localparam logic [CW-1:0]   DEPTH_COUNT = CW'(N);

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] occupancy;
  logic          push;
  logic          pop;
  logic [Nb-1:0] head_word;

  // Modulo-2**(M+1) difference of the pointers is the occupancy, including
  // the case where wr_ptr has wrapped and rd_ptr has not.
  assign occupancy = wr_ptr - rd_ptr;
  assign count     = occupancy;

  assign in_ready  = (occupancy != DEPTH_COUNT);
  assign out_valid = (occupancy != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement or block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  fifo_ram #(
    .Nb (Nb),
    .M  (M)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[M-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[M-1:0]),
    .rdata (head_word)
  );

  // Stale array contents are masked so downstream logic sees a clean 0.
  assign out_data = out_valid ? head_word : '0;

`ifdef SYNC_FIFO_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_COUNT = CW'(AF_LEVEL);

  logic [CW-1:0] next_count;

  // NOTE: next_count is assigned before the case so that every path through
  // this block drives it; otherwise synthesis would infer a latch.
  always_comb begin
    next_count = occupancy;
    case ({push, pop})
      2'b10:   next_count = occupancy + 1'b1;
      2'b01:   next_count = occupancy - 1'b1;
      default: next_count = occupancy;
    endcase
  end

  // Registered on the same edge as the pointers, so it always matches the
  // count that becomes visible after that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (next_count >= AF_COUNT);
    end
  end
`endif

endmodule : sync_word_fifo

// File: tb/tb_sync_word_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_word_fifo
// Self-checking bench for sync_word_fifo at M=2 (depth 4), Nb=32.
// A reference occupancy model and a queue of accepted words predict every
// flag, the count and the head word each cycle. Inputs change and outputs are
// sampled around the falling edge; the model advances on the rising edge.
// With SYNC_FIFO_ALMOST_FULL_EN the DUT is built with AF_LEVEL=3.
// -----------------------------------------------------------------------------
module tb_sync_word_fifo;

  localparam int NB    = 32;
  localparam int M     = 2;
  localparam int DEPTH = 2 ** M;

  logic          clk;
  logic          reset;
  logic          in_ready;
  logic          in_valid;
  logic [NB-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [NB-1:0] out_data;
  logic [M:0]    count;
`ifdef SYNC_FIFO_ALMOST_FULL_EN
  logic          almost_full;
  int            m_af;
`endif

  int            tests_run;
  int            tests_failed;
  int            m_count;
  logic [NB-1:0] sb_q[$];

  sync_word_fifo #(
    .Nb (NB),
    .M  (M)
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    ,
    .AF_LEVEL (3)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count)
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model, excluding the head word.
  task automatic check_flags();
    check("count",     32'(count),     32'(m_count));
    check("in_ready",  32'(in_ready),  32'(m_count != DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_count != 0));
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    check("almost_full", 32'(almost_full), 32'(m_af));
`endif
  endtask

  // One clock cycle: drive, check, predict, advance.
  task automatic cycle(input logic iv, input logic [NB-1:0] id, input logic ordy);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    check_flags();
    if (m_count != 0) check("out_data", out_data, sb_q[0]);
    else              check("out_data_empty", out_data, '0);
    do_push = iv && (m_count != DEPTH);
    do_pop  = ordy && (m_count != 0);
    if (do_pop)  void'(sb_q.pop_front());
    if (do_push) sb_q.push_back(id);
    @(posedge clk);
    m_count = m_count + int'(do_push) - int'(do_pop);
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    m_af = int'(m_count >= 3);
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_count      = 0;
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    m_af         = 0;
`endif
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // 1. Reset and idle.
    #12;
    check_flags();
    check("reset_out_data", out_data, '0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // 2. Fill with A0..A3, then offer A4 while full: it must not be stored.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
    cycle(1'b1, 32'hA4, 1'b0);
    cycle(1'b1, 32'hA4, 1'b0);

    // 3. Drain: A0..A3 in order, then empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // 4. Streaming from empty across several pointer wraps.
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // 5. Full with simultaneous push and pop offered: pop only.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b0);
    cycle(1'b1, 32'hBF, 1'b1);
    cycle(1'b1, 32'hC0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1);

    // 6. Asynchronous reset with three words held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    m_count = 0;
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    m_af = 0;
`endif
    check_flags();
    check("async_reset_out_data", out_data, '0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 32'hE0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

`ifdef SYNC_FIFO_ALMOST_FULL_EN
    // Almost-full at AF_LEVEL=3: sets after the third push, clears at 2.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hF0 + 32'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sync_word_fifo
